// File: rtl/seven_seg_capture_if.sv
// ---------------------------------------------------------------------------
// seven_seg_capture_if
//   Bundles the multiplexed seven-segment display nets (anode + segment) that
//   a display controller drives and a capture block observes.
//
//   Signals:
//     anode   [3:0] digit enables, active-low, one-hot-low when a digit is lit
//     segment [7:0] [6:0] segments g..a active-low, [7] decimal point active-low
//
//   Modports:
//     master : the display driver (drives anode/segment)
//     slave  : an observer such as seven_seg_capture (samples anode/segment)
// ---------------------------------------------------------------------------
interface seven_seg_capture_if;
  logic [3:0] anode;
  logic [7:0] segment;

  modport master (output anode, output segment);
  modport slave  (input  anode, input  segment);
endinterface

// File: rtl/seven_seg_capture.sv
// ---------------------------------------------------------------------------
// seven_seg_capture
//   Receive side of a multiplexed four-digit seven-segment display. Samples
//   the active-low anode/segment nets, requires a pattern to be stable for
//   STABLE_CYCLES consecutive samples, then decodes the lit digit back into a
//   hex nibble plus decimal point. Tracks which digits hold a valid value and
//   pulses frame_done once every digit has been captured since the last pulse.
//
//   Parameters:
//     STABLE_CYCLES : consecutive identical samples before a capture (2..255)
//
//   Ports:
//     clk          clock
//     reset        synchronous, active-high reset
//     seg_bus      slave view of anode[3:0] / segment[7:0]
//     data_out     [3:0] digit0 (anode[0]) ... [15:12] digit3
//     point_out    captured decimal points, active-high
//     digit_valid  bit i = digit i holds a successfully decoded value
//     err_count    (only with SEG_CAPTURE_ERRCNT_EN) saturating count of
//                  decode_err pulses, cleared only by reset
//     frame_done   one-cycle pulse when all four digits have been captured
//     decode_err   one-cycle pulse on a rejected capture
//
//   Optional feature macro: SEG_CAPTURE_ERRCNT_EN
// ---------------------------------------------------------------------------
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  seven_seg_capture_if.slave  seg_bus,
  output logic [15:0]         data_out,
  output logic [3:0]          point_out,
  output logic [3:0]          digit_valid,
`ifdef SEG_CAPTURE_ERRCNT_EN
  output logic [7:0]          err_count,
`endif
  output logic                frame_done,
  output logic                decode_err
);

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  // -------------------------------------------------------------------------
  // Stability tracking
  // -------------------------------------------------------------------------
  logic [11:0] sample;
  logic [11:0] prev_sample_reg;
  logic [7:0]  run_count_reg;
  logic [7:0]  run_count_next;
  logic        capture;

  always_comb begin
    sample = {seg_bus.anode, seg_bus.segment};
  end

  // A fresh pattern counts as the first sample of a new run; the counter
  // saturates so a long-held pattern cannot wrap around and retrigger.
  always_comb begin
    run_count_next = 8'd1;
    if (sample == prev_sample_reg) begin
      if (run_count_reg == STABLE_CNT) begin
        run_count_next = STABLE_CNT;
      end else begin
        run_count_next = run_count_reg + 8'd1;
      end
    end
  end

  // Fires only on the transition into the saturated value.
  always_comb begin
    capture = (run_count_next == STABLE_CNT) && (run_count_reg != STABLE_CNT);
  end

  // -------------------------------------------------------------------------
  // Anode classification
  // -------------------------------------------------------------------------
  logic [3:0] anode_lit;
  logic       anode_blank;
  logic       anode_one_hot;
  logic       anode_multi;

  always_comb begin
    anode_lit     = ~seg_bus.anode;
    anode_blank   = (anode_lit == 4'b0000);
    anode_one_hot = $onehot(anode_lit);
    anode_multi   = !anode_blank && !anode_one_hot;
  end

  // -------------------------------------------------------------------------
  // Segment decode (active-low g..a)
  // -------------------------------------------------------------------------
  logic       dec_hit;
  logic [3:0] dec_value;

  always_comb begin
    dec_hit   = 1'b1;
    dec_value = 4'h0;
    case (seg_bus.segment[6:0])
      7'b1000000: dec_value = 4'h0;
      7'b1111001: dec_value = 4'h1;
      7'b0100100: dec_value = 4'h2;
      7'b0110000: dec_value = 4'h3;
      7'b0011001: dec_value = 4'h4;
      7'b0010010: dec_value = 4'h5;
      7'b0000010: dec_value = 4'h6;
      7'b1111000: dec_value = 4'h7;
      7'b0000000: dec_value = 4'h8;
      7'b0010000: dec_value = 4'h9;
      7'b0001000: dec_value = 4'hA;
      7'b0000011: dec_value = 4'hB;
      7'b1000110: dec_value = 4'hC;
      7'b0100001: dec_value = 4'hD;
      7'b0000110: dec_value = 4'hE;
      7'b0001110: dec_value = 4'hF;
      default: begin
        dec_hit   = 1'b0;
        dec_value = 4'h0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Per-digit next-state
  // -------------------------------------------------------------------------
  logic [15:0] data_reg;
  logic [15:0] data_next;
  logic [3:0]  point_reg;
  logic [3:0]  point_next;
  logic [3:0]  valid_reg;
  logic [3:0]  valid_next;
  logic [3:0]  digit_sel;
  logic [3:0]  hit_mask;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      // Only a one-hot-low anode selects a digit; multi-lit patterns never do.
      assign digit_sel[gi] = capture && anode_one_hot && anode_lit[gi];
      assign hit_mask[gi]  = digit_sel[gi] && dec_hit;

      // A decode miss keeps the previous nibble and dp, but drops validity.
      assign data_next[4*gi +: 4] = hit_mask[gi] ? dec_value : data_reg[4*gi +: 4];
      assign point_next[gi]       = hit_mask[gi] ? ~seg_bus.segment[7] : point_reg[gi];
      assign valid_next[gi]       = digit_sel[gi] ? dec_hit : valid_reg[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Frame tracking and error pulse
  // -------------------------------------------------------------------------
  logic [3:0] seen_mask_reg;
  logic [3:0] seen_mask_next;
  logic       frame_done_reg;
  logic       frame_done_next;
  logic       decode_err_reg;
  logic       decode_err_next;

  // The full mask is reported one edge after it forms and cleared on that
  // same edge; a capture landing on that edge seeds the new frame.
  always_comb begin
    frame_done_next = (seen_mask_reg == 4'b1111);
    seen_mask_next  = (frame_done_next ? 4'b0000 : seen_mask_reg) | hit_mask;
    decode_err_next = capture && (anode_multi || (anode_one_hot && !dec_hit));
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sample_reg <= 12'h000;
      run_count_reg   <= 8'd0;
      data_reg        <= 16'h0000;
      point_reg       <= 4'b0000;
      valid_reg       <= 4'b0000;
      seen_mask_reg   <= 4'b0000;
      frame_done_reg  <= 1'b0;
      decode_err_reg  <= 1'b0;
    end else begin
      prev_sample_reg <= sample;
      run_count_reg   <= run_count_next;
      data_reg        <= data_next;
      point_reg       <= point_next;
      valid_reg       <= valid_next;
      seen_mask_reg   <= seen_mask_next;
      frame_done_reg  <= frame_done_next;
      decode_err_reg  <= decode_err_next;
    end
  end

  assign data_out    = data_reg;
  assign point_out   = point_reg;
  assign digit_valid = valid_reg;
  assign frame_done  = frame_done_reg;
  assign decode_err  = decode_err_reg;

`ifdef SEG_CAPTURE_ERRCNT_EN
  // -------------------------------------------------------------------------
  // Saturating error counter, counted on the same edge the pulse is issued
  // -------------------------------------------------------------------------
  logic [7:0] err_count_reg;
  logic [7:0] err_count_next;

  always_comb begin
    err_count_next = err_count_reg;
    if (decode_err_next && (err_count_reg != 8'hFF)) begin
      err_count_next = err_count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_reg <= 8'h00;
    end else begin
      err_count_reg <= err_count_next;
    end
  end

  assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_capture
//   Scoreboard bench: the stimulus process steps a behavioural model once per
//   clock edge and queues the expected output snapshot whenever the model
//   predicts a visible event (pulse or output change). A monitor compares the
//   DUT at every falling edge against the queue head, including edge timing.
// ---------------------------------------------------------------------------
module tb_seven_seg_capture;

  localparam int S = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seven_seg_capture_if bus ();

  logic [15:0] data_out;
  logic [3:0]  point_out;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        decode_err;
`ifdef SEG_CAPTURE_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  seven_seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_bus     (bus),
    .data_out    (data_out),
    .point_out   (point_out),
    .digit_valid (digit_valid),
`ifdef SEG_CAPTURE_ERRCNT_EN
    .err_count   (err_count),
`endif
    .frame_done  (frame_done),
    .decode_err  (decode_err)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  v;
    logic        fd;
    logic        de;
    logic [7:0]  ec;
  } out_t;

  typedef struct packed {
    int   edge_no;
    out_t o;
  } exp_t;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Active-low segment patterns for hex digits 0..F.
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // ---------------- behavioural model ----------------
  out_t        m_out  = '0;
  logic [3:0]  m_seen = 4'b0000;
  logic [11:0] m_hist[$];

  function automatic void model_step(input logic rst, input logic [11:0] smp, input int edge_no);
    out_t       prev;
    int         run;
    int         nz;
    int         idx;
    logic       hit;
    logic [3:0] val;
    logic       err;
    prev     = m_out;
    m_out.fd = 1'b0;
    m_out.de = 1'b0;
    err      = 1'b0;
    if (rst) begin
      m_out  = '0;
      m_seen = 4'b0000;
      m_hist.delete();
    end else begin
      if (m_seen == 4'b1111) begin
        m_out.fd = 1'b1;
        m_seen   = 4'b0000;
      end
      m_hist.push_back(smp);
      if (m_hist.size() > 300) void'(m_hist.pop_front());
      run = 0;
      for (int k = m_hist.size() - 1; k >= 0; k--) begin
        if (m_hist[k] == smp) run++;
        else break;
      end
      if (run == S) begin
        nz  = 0;
        idx = 0;
        for (int k = 0; k < 4; k++) begin
          if (!smp[8+k]) begin
            nz++;
            idx = k;
          end
        end
        if (nz > 1) begin
          err = 1'b1;
        end else if (nz == 1) begin
          hit = 1'b0;
          val = 4'h0;
          for (int k = 0; k < 16; k++) begin
            if (seg_tab[k] == smp[6:0]) begin
              hit = 1'b1;
              val = 4'(k);
            end
          end
          if (hit) begin
            m_out.d[4*idx +: 4] = val;
            m_out.p[idx]        = ~smp[7];
            m_out.v[idx]        = 1'b1;
            m_seen[idx]         = 1'b1;
          end else begin
            m_out.v[idx] = 1'b0;
            err          = 1'b1;
          end
        end
      end
      if (err) begin
        m_out.de = 1'b1;
`ifdef SEG_CAPTURE_ERRCNT_EN
        if (m_out.ec != 8'hFF) m_out.ec = m_out.ec + 8'd1;
`endif
      end
    end
    if (m_out.fd || m_out.de ||
        ({m_out.d, m_out.p, m_out.v, m_out.ec} != {prev.d, prev.p, prev.v, prev.ec})) begin
      exp_q.push_back('{edge_no: edge_no, o: m_out});
    end
  endfunction

  // Drive one pattern for n edges, stepping the model for each edge.
  task automatic drive(input logic rst, input logic [3:0] a, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      reset       = rst;
      bus.anode   = a;
      bus.segment = s;
      model_step(rst, {a, s}, cyc + 1);
      @(negedge clk);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    out_t obs;
    out_t last_obs;
    exp_t e;
    logic interesting;
    last_obs = '0;
    forever begin
      @(negedge clk);
      obs.d  = data_out;
      obs.p  = point_out;
      obs.v  = digit_valid;
      obs.fd = frame_done;
      obs.de = decode_err;
`ifdef SEG_CAPTURE_ERRCNT_EN
      obs.ec = err_count;
`else
      obs.ec = 8'h00;
`endif
      if (cyc == 1) begin
        checks++;
        if (obs != '0) begin
          failures++;
          $display("FAIL reset_state edge=%0d got=%h want=0", cyc, obs);
        end
      end
      interesting = obs.fd || obs.de ||
                    ({obs.d, obs.p, obs.v, obs.ec} != {last_obs.d, last_obs.p, last_obs.v, last_obs.ec});
      if (exp_q.size() > 0 && exp_q[0].edge_no == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (!interesting || obs != e.o) begin
          failures++;
          $display("FAIL event edge=%0d got d=%h p=%b v=%b fd=%b de=%b ec=%0d want d=%h p=%b v=%b fd=%b de=%b ec=%0d",
                   cyc, obs.d, obs.p, obs.v, obs.fd, obs.de, obs.ec,
                   e.o.d, e.o.p, e.o.v, e.o.fd, e.o.de, e.o.ec);
        end else begin
          $display("event edge=%0d d=%h p=%b v=%b fd=%b de=%b ec=%0d ok",
                   cyc, obs.d, obs.p, obs.v, obs.fd, obs.de, obs.ec);
        end
      end else if (interesting) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event edge=%0d got d=%h p=%b v=%b fd=%b de=%b ec=%0d want no event",
                 cyc, obs.d, obs.p, obs.v, obs.fd, obs.de, obs.ec);
      end
      last_obs = obs;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] a;
    logic [7:0] s;
    int         sel;
    int         hold;
    drive(1'b1, 4'hF, 8'hFF, 2);

    // single digit capture, then long hold
    drive(1'b0, 4'b1110, 8'b1_1000000, 24);
    // glitch: 3 stable samples then segment changes
    drive(1'b0, 4'b1101, 8'b1_1111001, 3);
    drive(1'b0, 4'b1101, 8'b1_0110000, 2);
    drive(1'b0, 4'hF, 8'hFF, 2);

    // full frame 5,9,0,2 (dp on digit2) from a clean state
    drive(1'b1, 4'hF, 8'hFF, 1);
    drive(1'b0, 4'b0111, 8'b1_0010010, 6);
    drive(1'b0, 4'b1011, 8'b0_0010000, 6);
    drive(1'b0, 4'b1101, 8'b1_1000000, 6);
    drive(1'b0, 4'b1110, 8'b1_0100100, 6);
    drive(1'b0, 4'hF, 8'hFF, 3);

    // errors: blank segments on a lit digit, and two anodes lit
    drive(1'b0, 4'b1101, 8'hFF, 4);
    drive(1'b0, 4'hF, 8'hFF, 1);
    drive(1'b0, 4'b1100, 8'b1_1000000, 5);

    // reset after two-digit capture, then 3-edge and 4-edge holds
    drive(1'b0, 4'b1110, 8'b1_0011001, 5);
    drive(1'b0, 4'b1101, 8'b0_0001000, 5);
    drive(1'b1, 4'b1101, 8'b0_0001000, 1);
    drive(1'b0, 4'b1011, 8'b1_0000110, 3);
    drive(1'b0, 4'b0111, 8'b1_1000110, 4);

    // randomized patterns
    for (int t = 0; t < 400; t++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: a = 4'b1110;
        1: a = 4'b1101;
        2: a = 4'b1011;
        3: a = 4'b0111;
        4: a = 4'b1111;
        default: a = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 3) != 0) s = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 15)]};
      else s = 8'($urandom_range(0, 255));
      hold = int'($urandom_range(1, 8));
      if ($urandom_range(0, 99) < 2) drive(1'b1, a, s, 1);
      else drive(1'b0, a, s, hold);
    end

`ifdef SEG_CAPTURE_ERRCNT_EN
    // 300 rejected captures saturate the counter; reset clears it
    for (int t = 0; t < 300; t++) begin
      if (t % 2 == 0) drive(1'b0, 4'b1100, 8'b1_1000000, S);
      else drive(1'b0, 4'b0011, 8'b1_1000000, S);
    end
    drive(1'b1, 4'hF, 8'hFF, 1);
`endif

    drive(1'b0, 4'hF, 8'hFF, 4);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
